// File: rtl/alu_arbiter_pkg.sv
// Shared encodings for the two-requester ALU arbiter: FSM states and ALU opcodes.
package alu_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StResp = 2'd2
    } arb_state_e;

    localparam logic [3:0] ALU_OP_NOP = 4'h0;
    localparam logic [3:0] ALU_OP_ADD = 4'h1;
    localparam logic [3:0] ALU_OP_SUB = 4'h2;

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester and ALU-side signals of the arbiter, bundled; master drives requests and
// ALU results, slave is the arbiter itself.
interface alu_arbiter_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned OP_W   = 4
);
    logic              req0;
    logic [OP_W-1:0]   op0;
    logic [DATA_W-1:0] a0;
    logic [DATA_W-1:0] b0;
    logic              ack0;
    logic              req1;
    logic [OP_W-1:0]   op1;
    logic [DATA_W-1:0] a1;
    logic [DATA_W-1:0] b1;
    logic              ack1;
    logic [DATA_W-1:0] regc;
    logic              neg;
    logic              zero;
    logic              busy;
    logic [OP_W-1:0]   alu_op;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_c;
    logic              alu_neg;
    logic              alu_zero;

    modport master (
        output req0, op0, a0, b0, req1, op1, a1, b1, alu_c, alu_neg, alu_zero,
        input  ack0, ack1, regc, neg, zero, busy, alu_op, alu_a, alu_b
    );

    modport slave (
        input  req0, op0, a0, b0, req1, op1, a1, b1, alu_c, alu_neg, alu_zero,
        output ack0, ack1, regc, neg, zero, busy, alu_op, alu_a, alu_b
    );
endinterface

// File: rtl/alu_arb_pick.sv
// Combinational 2-way grant chooser: round robin on the last grant, or requester 0
// always winning ties when FixedPrio is set.
module alu_arb_pick #(
    parameter bit FixedPrio = 1'b0
) (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic gnt,
    output logic valid
);
    always_comb begin
        valid = req0 | req1;
        if (req0 && req1) begin
            gnt = FixedPrio ? 1'b0 : ~last;
        end else begin
            gnt = req1;
        end
    end
endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two requesters: grant, latch, execute, respond.
// Build option ALU_ARB_FIXED_PRIO_EN makes requester 0 win every tie.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned OP_W   = 4
) (
    input logic           iClk,
    input logic           iRst_n,
    alu_arbiter_if.slave  bus
);
`ifdef ALU_ARB_FIXED_PRIO_EN
    localparam bit FixedPrio = 1'b1;
`else
    localparam bit FixedPrio = 1'b0;
`endif

    arb_state_e        state_q;
    logic              gnt_q;
    logic              last_q;
    logic [OP_W-1:0]   alu_op_q;
    logic [DATA_W-1:0] alu_a_q;
    logic [DATA_W-1:0] alu_b_q;
    logic              ack0_q;
    logic              ack1_q;
    logic [DATA_W-1:0] regc_q;
    logic              neg_q;
    logic              zero_q;
    logic              busy_q;

    logic pick_gnt;
    logic pick_valid;

    alu_arb_pick #(
        .FixedPrio (FixedPrio)
    ) u_pick (
        .req0  (bus.req0),
        .req1  (bus.req1),
        .last  (last_q),
        .gnt   (pick_gnt),
        .valid (pick_valid)
    );

    // The operand latches double as the ALU drive: loaded on grant, cleared when leaving
    // EXEC, so the ALU sees op 0 whenever no operation is in flight.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            state_q  <= StIdle;
            gnt_q    <= 1'b0;
            last_q   <= 1'b1;
            alu_op_q <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            regc_q   <= '0;
            neg_q    <= 1'b0;
            zero_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    ack0_q <= 1'b0;
                    ack1_q <= 1'b0;
                    if (pick_valid) begin
                        gnt_q    <= pick_gnt;
                        alu_op_q <= pick_gnt ? bus.op1 : bus.op0;
                        alu_a_q  <= pick_gnt ? bus.a1  : bus.a0;
                        alu_b_q  <= pick_gnt ? bus.b1  : bus.b0;
                        busy_q   <= 1'b1;
                        state_q  <= StExec;
                    end
                end
                StExec: begin
                    regc_q   <= bus.alu_c;
                    neg_q    <= bus.alu_neg;
                    zero_q   <= bus.alu_zero;
                    last_q   <= gnt_q;
                    alu_op_q <= '0;
                    alu_a_q  <= '0;
                    alu_b_q  <= '0;
                    ack0_q   <= ~gnt_q;
                    ack1_q   <= gnt_q;
                    state_q  <= StResp;
                end
                StResp: begin
                    ack0_q  <= 1'b0;
                    ack1_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.ack0   = ack0_q;
    assign bus.ack1   = ack1_q;
    assign bus.regc   = regc_q;
    assign bus.neg    = neg_q;
    assign bus.zero   = zero_q;
    assign bus.busy   = busy_q;
    assign bus.alu_op = alu_op_q;
    assign bus.alu_a  = alu_a_q;
    assign bus.alu_b  = alu_b_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural add/sub ALU on the ALU ports.
// Honours ALU_ARB_FIXED_PRIO_EN when checking the simultaneous-request sequence.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    int   cyc;

    alu_arbiter_if #(.DATA_W(32), .OP_W(4)) bus ();

    alu_arbiter #(
        .DATA_W (32),
        .OP_W   (4)
    ) dut (
        .iClk   (clk),
        .iRst_n (rst_n),
        .bus    (bus)
    );

    // Reference ALU: add, sub, anything else yields 0
    assign bus.alu_c    = (bus.alu_op == ALU_OP_ADD) ? bus.alu_a + bus.alu_b :
                          (bus.alu_op == ALU_OP_SUB) ? bus.alu_a - bus.alu_b : 32'h0;
    assign bus.alu_neg  = bus.alu_c[31];
    assign bus.alu_zero = (bus.alu_c == 32'h0);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for an ack, checks who got it and the result, then checks the pulse ends.
    task automatic wait_ack(input string tag, input logic exp_id, input logic [31:0] c,
                            input logic n, input logic z, output int ncyc);
        logic [1:0] exp_acks;
        ncyc = 0;
        while (!(bus.ack0 || bus.ack1) && ncyc < 8) begin
            tick();
            ncyc++;
        end
        if (!(bus.ack0 || bus.ack1)) begin
            checks++;
            errors++;
            $error("FAIL %s_timeout: observed no ack expected ack within 8 cycles", tag);
        end else begin
            exp_acks = exp_id ? 2'b10 : 2'b01;
            check({tag, "_ackid"}, {30'h0, bus.ack1, bus.ack0}, {30'h0, exp_acks});
            check({tag, "_regc"}, bus.regc, c);
            check({tag, "_neg"}, {31'h0, bus.neg}, {31'h0, n});
            check({tag, "_zero"}, {31'h0, bus.zero}, {31'h0, z});
            tick();
            check({tag, "_pulse"}, {30'h0, bus.ack1, bus.ack0}, 32'h0);
        end
    endtask

    initial begin
        #100000;
        $error("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "simulation stuck");
    end

    initial begin
        logic exp_id;
        rst_n = 1'b0;
        bus.req0 = 1'b0; bus.op0 = '0; bus.a0 = '0; bus.b0 = '0;
        bus.req1 = 1'b0; bus.op1 = '0; bus.a1 = '0; bus.b1 = '0;
        tick();
        tick();
        check("rst_regc", bus.regc, 32'h0);
        check("rst_flags", {29'h0, bus.neg, bus.zero, bus.busy}, 32'h0);
        check("rst_acks", {30'h0, bus.ack1, bus.ack0}, 32'h0);
        check("rst_aluop", {28'h0, bus.alu_op}, 32'h0);
        rst_n = 1'b1;

        // Single requester 0: add 5+7
        bus.req0 = 1'b1; bus.op0 = ALU_OP_ADD; bus.a0 = 32'd5; bus.b0 = 32'd7;
        tick();
        check("t1_busy", {31'h0, bus.busy}, 32'h1);
        check("t1_aluop", {28'h0, bus.alu_op}, 32'h1);
        check("t1_alua", bus.alu_a, 32'd5);
        check("t1_alub", bus.alu_b, 32'd7);
        check("t1_noack_exec", {30'h0, bus.ack1, bus.ack0}, 32'h0);
        wait_ack("t1", 1'b0, 32'd12, 1'b0, 1'b0, cyc);
        check("t1_latency", cyc, 32'd1);
        bus.req0 = 1'b0;
        check("t1_idle_busy", {31'h0, bus.busy}, 32'h0);
        check("t1_idle_aluop", {28'h0, bus.alu_op}, 32'h0);

        // Single requester 1: sub 3-8
        bus.req1 = 1'b1; bus.op1 = ALU_OP_SUB; bus.a1 = 32'd3; bus.b1 = 32'd8;
        tick();
        wait_ack("t2", 1'b1, 32'hFFFF_FFFB, 1'b1, 1'b0, cyc);
        bus.req1 = 1'b0;

        // Both requesting continuously
        bus.req0 = 1'b1; bus.op0 = ALU_OP_ADD; bus.a0 = 32'd1; bus.b0 = 32'd1;
        bus.req1 = 1'b1; bus.op1 = ALU_OP_SUB; bus.a1 = 32'd4; bus.b1 = 32'd4;
        for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            exp_id = 1'b0;
`else
            exp_id = (i % 2) == 1;
`endif
            if (exp_id) wait_ack($sformatf("t3_%0d", i), 1'b1, 32'h0, 1'b0, 1'b1, cyc);
            else        wait_ack($sformatf("t3_%0d", i), 1'b0, 32'd2, 1'b0, 1'b0, cyc);
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;

        // Operands changed and request dropped after grant
        bus.req0 = 1'b1; bus.op0 = ALU_OP_ADD; bus.a0 = 32'd10; bus.b0 = 32'd20;
        tick();
        bus.a0 = 32'd100;
        bus.req0 = 1'b0;
        wait_ack("t4", 1'b0, 32'd30, 1'b0, 1'b0, cyc);

        // Reset during EXEC drops the operation
        bus.req1 = 1'b1; bus.op1 = ALU_OP_ADD; bus.a1 = 32'd1; bus.b1 = 32'd2;
        tick();
        check("t5_exec_busy", {31'h0, bus.busy}, 32'h1);
        rst_n = 1'b0;
        bus.req1 = 1'b0;
        tick();
        check("t5_rst_acks", {30'h0, bus.ack1, bus.ack0}, 32'h0);
        check("t5_rst_regc", bus.regc, 32'h0);
        check("t5_rst_busy", {31'h0, bus.busy}, 32'h0);
        check("t5_rst_alua", bus.alu_a, 32'h0);
        tick();
        check("t5_rst_noack", {30'h0, bus.ack1, bus.ack0}, 32'h0);
        rst_n = 1'b1;
        bus.req0 = 1'b1; bus.op0 = ALU_OP_ADD; bus.a0 = 32'd2; bus.b0 = 32'd2;
        bus.req1 = 1'b1; bus.op1 = ALU_OP_ADD; bus.a1 = 32'd3; bus.b1 = 32'd3;
        tick();
        check("t5_first_gnt_a", bus.alu_a, 32'd2);
        wait_ack("t5", 1'b0, 32'd4, 1'b0, 1'b0, cyc);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;

        // Unsupported opcode, then subtraction wrap
        bus.req0 = 1'b1; bus.op0 = 4'h7; bus.a0 = 32'd9; bus.b0 = 32'd9;
        tick();
        wait_ack("t6", 1'b0, 32'h0, 1'b0, 1'b1, cyc);
        bus.req0 = 1'b0;
        bus.req1 = 1'b1; bus.op1 = ALU_OP_SUB; bus.a1 = 32'h8000_0000; bus.b1 = 32'd1;
        tick();
        wait_ack("t7", 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b0, cyc);
        bus.req1 = 1'b0;
        tick();
        check("t7_hold_regc", bus.regc, 32'h7FFF_FFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
